axi4l_cmd_master: RTL and testbench

Command-driven AXI4-Lite initiator: it turns single-word read/write requests from a simple valid/ready command port into fully handshaked AXI4-Lite transactions, one at a time. It returns each transaction's data and response code on a held response port. It is the generic initiator end for the existing `Axi4LiteIf` slaves such as `Axi4LiteSlave`, and replaces hard-coded example masters in benches and systems.

---
 rtl/axi4l_cmd_master.sv | 196 +++++++++++++++++++
 tb/tb_axi4l_cmd_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_cmd_master.sv
// axi4l_cmd_master
//   Command-driven AXI4-Lite initiator. Accepts one single-word read or write
//   on a valid/ready command port, runs it as a fully handshaked AXI4-Lite
//   transaction, and presents the result on a held valid/ready response port.
//   Only one transaction is in flight at any time.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_wr, cmd_addr,
//   cmd_wdata, cmd_wstrb        command payload (wstrb ignored for reads)
//   rsp_valid/rsp_ready         response handshake, payload held until taken
//   rsp_wr, rsp_rdata, rsp_resp response payload (rdata is 0 for writes)
//   err_cnt                     saturating count of responses with resp[1]=1
//   aw*, w*, b*, ar*, r*        AXI4-Lite initiator channels, 32-bit data
module axi4l_cmd_master #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    // command port
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    input  logic [3:0]    cmd_wstrb,
    // response port
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_wr,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_resp,
    output logic [15:0]   err_cnt,
    // AXI write address
    output logic [AW-1:0] awaddr,
    output logic [2:0]    awprot,
    output logic          awvalid,
    input  logic          awready,
    // AXI write data
    output logic [31:0]   wdata,
    output logic [3:0]    wstrb,
    output logic          wvalid,
    input  logic          wready,
    // AXI write response
    input  logic [1:0]    bresp,
    input  logic          bvalid,
    output logic          bready,
    // AXI read address
    output logic [AW-1:0] araddr,
    output logic [2:0]    arprot,
    output logic          arvalid,
    input  logic          arready,
    // AXI read data
    input  logic [31:0]   rdata,
    input  logic [1:0]    rresp,
    input  logic          rvalid,
    output logic          rready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RSP   = 3'd5
    } state_t;

    state_t      state;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic [15:0] err_nxt;

    assign awprot = 3'b000;
    assign arprot = 3'b000;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Saturating error increment, applied only on entry to RSP.
    assign err_nxt = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;

    // cmd_ready is a flop that is high exactly when state is IDLE, except
    // that it stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_resp  <= 2'b00;
            err_cnt   <= 16'h0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= 32'h0;
            wstrb     <= 4'h0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_wr    <= cmd_wr;
                        if (cmd_wr) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WADDR;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end
                    end
                end

                // AW and W complete independently; leave once both have
                // handshaked, counting a handshake happening on this edge.
                WADDR: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WRESP;
                    end
                end

                WRESP: begin
                    if (bvalid && bready) begin
                        bready    <= 1'b0;
                        rsp_resp  <= bresp;
                        rsp_rdata <= 32'h0;
                        rsp_valid <= 1'b1;
                        if (bresp[1]) err_cnt <= err_nxt;
                        state     <= RSP;
                    end
                end

                RADDR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end

                RDATA: begin
                    if (rvalid && rready) begin
                        rready    <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rsp_valid <= 1'b1;
                        if (rresp[1]) err_cnt <= err_nxt;
                        state     <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// tb_axi4l_cmd_master
//   Directed and random bench for axi4l_cmd_master. Contains a small AXI4-Lite
//   slave memory (8 words) with programmable per-channel wait states and
//   read-error injection, a reference memory for read data, and a monitor for
//   valid/payload stability and bready ordering.
module tb_axi4l_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_cnt;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi4l_cmd_master #(.AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_cnt(err_cnt),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // ---------------- slave model ----------------
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic        r_err = 1'b0;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;
    logic [4:0]  aw_lat, ar_lat;
    logic [31:0] w_lat;
    logic [3:0]  ws_lat;
    int          aw_hs_n = 0, w_hs_n = 0;
    logic [31:0] mem [8] = '{default: 32'h0};
    logic [4:0]  ea, eaa;
    logic [31:0] ed;
    logic [3:0]  es;

    assign awready = !aw_got && (aw_cnt >= aw_wait);
    assign wready  = !w_got  && (w_cnt  >= w_wait);
    assign arready = !ar_got && (ar_cnt >= ar_wait);
    assign bresp   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
            aw_lat <= '0; ar_lat <= '0; w_lat <= '0; ws_lat <= '0;
        end else begin
            ea  = aw_got ? aw_lat : awaddr;
            ed  = w_got ? w_lat : wdata;
            es  = w_got ? ws_lat : wstrb;
            eaa = ar_got ? ar_lat : araddr;
            if (awvalid && awready) begin
                aw_got <= 1'b1; aw_lat <= awaddr; aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1;
            end else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                w_got <= 1'b1; w_lat <= wdata; ws_lat <= wstrb; w_cnt <= 0; w_hs_n <= w_hs_n + 1;
            end else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                if (b_cnt >= b_wait) begin
                    bvalid <= 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (es[b]) mem[ea[4:2]][8*b +: 8] <= ed[8*b +: 8];
                end else b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                ar_got <= 1'b1; ar_lat <= araddr; ar_cnt <= 0;
            end else if (arvalid && !ar_got) ar_cnt <= ar_cnt + 1;
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
            end else if (!rvalid && (ar_got || (arvalid && arready))) begin
                if (r_cnt >= r_wait) begin
                    rvalid <= 1'b1; rdata <= mem[eaa[4:2]]; rresp <= r_err ? 2'b10 : 2'b00;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- stability / ordering monitor ----------------
    int          stab_viol = 0, bready_viol = 0;
    logic        p_aw, p_w, p_ar;
    logic [4:0]  p_awaddr, p_araddr;
    logic [35:0] p_wpay;

    always @(posedge clk) begin
        if (!rst_n) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
        end else begin
            if (p_aw && (!awvalid || awaddr != p_awaddr)) stab_viol <= stab_viol + 1;
            if (p_w && (!wvalid || {wstrb, wdata} != p_wpay)) stab_viol <= stab_viol + 1;
            if (p_ar && (!arvalid || araddr != p_araddr)) stab_viol <= stab_viol + 1;
            if (bready && !(aw_got && w_got)) bready_viol <= bready_viol + 1;
            p_aw <= awvalid && !awready; p_awaddr <= awaddr;
            p_w  <= wvalid && !wready;   p_wpay   <= {wstrb, wdata};
            p_ar <= arvalid && !arready; p_araddr <= araddr;
        end
    end

    // ---------------- checking ----------------
    int checks = 0, fails = 0;
    logic [31:0] ref_mem [8] = '{default: 32'h0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command and wait for its response. Leaves the response
    // pending (not yet taken) when rsp_ready is low.
    task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd,
                          output logic [1:0] rr, output int lat);
        int n;
        cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("rsp_arrive", rsp_valid, 1);
        rd = rsp_rdata; rr = rsp_resp; lat = n;
        if (wr && rsp_valid)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[4:2]][8*b +: 8] = d[8*b +: 8];
        if (rsp_ready) begin @(posedge clk); #1; end
    endtask

    task automatic set_waits(input int aw, input int w, input int b, input int ar, input int r);
        aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, hold_d, exp;
        logic [1:0]  rr;
        int          lat, a0, w0, n;
        logic [4:0]  ad;
        logic        wr;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("rst_payload", {rsp_rdata, rsp_resp, err_cnt, awaddr, araddr}, 0);
        chk("rst_wpay", {wdata, wstrb}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);
        chk("prot", {awprot, arprot}, 0);

        // zero-wait write then read
        do_cmd(1, 5'h08, 32'hDEADBEEF, 4'hF, rd, rr, lat);
        chk("wr_lat", lat, 3);
        chk("wr_resp", rr, 2'b00);
        chk("wr_rdata0", rd, 0);
        chk("cmd_ready_cycle4", cmd_ready, 1);
        do_cmd(0, 5'h08, 0, 0, rd, rr, lat);
        chk("rd_lat", lat, 3);
        chk("rd_data", rd, 32'hDEADBEEF);

        // skewed write channels: awready first, wready first, same cycle
        for (int k = 0; k < 3; k++) begin
            if (k == 0) set_waits(0, 3, 0, 0, 0);
            else if (k == 1) set_waits(3, 0, 0, 0, 0);
            else set_waits(2, 2, 1, 0, 0);
            a0 = aw_hs_n; w0 = w_hs_n;
            do_cmd(1, 5'h10 + 5'(4 * k), 32'h1000 + k, 4'hF, rd, rr, lat);
            chk("skew_aw_hs", aw_hs_n - a0, 1);
            chk("skew_w_hs", w_hs_n - w0, 1);
            chk("skew_bready_order", bready_viol, 0);
        end
        set_waits(0, 0, 0, 0, 0);
        do_cmd(0, 5'h14, 0, 0, rd, rr, lat);
        chk("skew_rdback", rd, 32'h1001);

        // partial strobe
        do_cmd(1, 5'h04, 32'h11223344, 4'hF, rd, rr, lat);
        do_cmd(1, 5'h04, 32'hAABBCCDD, 4'b0101, rd, rr, lat);
        do_cmd(0, 5'h04, 0, 0, rd, rr, lat);
        chk("strobe_merge", rd, 32'h11BB33DD);

        // error responses
        r_err = 1'b1;
        for (int k = 0; k < 3; k++) do_cmd(0, 5'h08, 0, 0, rd, rr, lat);
        chk("err_resp", rr, 2'b10);
        chk("err_cnt3", err_cnt, 3);
        r_err = 1'b0;

        // response back-pressure
        rsp_ready = 1'b0;
        do_cmd(0, 5'h04, 0, 0, rd, rr, lat);
        hold_d = rsp_rdata;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_payload", {rsp_wr, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h11BB33DD});
            chk("bp_hold", rsp_rdata, hold_d);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_ready", cmd_ready, 1);

        // reset while waiting for BVALID
        set_waits(0, 0, 10, 0, 0);
        cmd_wr = 1'b1; cmd_addr = 5'h1C; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!bready && n < 50) begin @(posedge clk); #1; n++; end
        chk("mid_in_wresp", {bready, bvalid}, 2'b10);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("mid_rst_err", err_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        set_waits(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_no_rsp", rsp_valid, 0);
        do_cmd(0, 5'h1C, 0, 0, rd, rr, lat);
        chk("mid_no_write", rd, 32'h0);

        // random stress
        for (int i = 0; i < 1000; i++) begin
            set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            ad = {3'($urandom_range(0, 7)), 2'b00};
            exp = ref_mem[ad[4:2]];
            do_cmd(wr, ad, $urandom, 4'($urandom_range(0, 15)), rd, rr, lat);
            if (!wr) chk("stress_rd", rd, exp);
        end
        chk("stress_stability", stab_viol, 0);
        chk("stress_bready_order", bready_viol, 0);
        chk("stress_err_cnt", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
